// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg_n universal shift register: operating modes
// and burst controller states.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SHREG_HOLD = 2'd0,
    SHREG_SHL  = 2'd1,
    SHREG_SHR  = 2'd2,
    SHREG_LOAD = 2'd3
  } shreg_mode_e;

  typedef enum logic {
    SHREG_IDLE  = 1'b0,
    SHREG_BURST = 1'b1
  } shreg_state_e;

endpackage

// File: rtl/shift_reg_ctrl.sv
// Burst controller for shift_reg_n: IDLE/BURST FSM with a down-counter.
// Decides each cycle whether the datapath shifts and in which direction.
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_len,
  output logic             busy,
  output logic             done,
  output logic             shift_en,
  output logic             shift_right
);

  shreg_state_e     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             dir_q, dir_next;
  logic             done_next;
  logic [CNT_W-1:0] len_sat;
  shreg_mode_e      mode_e;
  logic             is_shift;

  assign mode_e   = shreg_mode_e'(mode);
  assign is_shift = (mode_e == SHREG_SHL) || (mode_e == SHREG_SHR);
  assign len_sat  = (shift_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_len;
  assign busy     = (state == SHREG_BURST);

  always_comb begin
    state_next  = state;
    count_next  = count;
    dir_next    = dir_q;
    done_next   = 1'b0;
    shift_en    = 1'b0;
    shift_right = dir_q;
    case (state)
      SHREG_IDLE: begin
        shift_right = (mode_e == SHREG_SHR);
        if (start && is_shift) begin
          // A zero-length burst only reports completion.
          if (len_sat == '0) begin
            done_next = 1'b1;
          end else begin
            shift_en   = 1'b1;
            dir_next   = (mode_e == SHREG_SHR);
            count_next = len_sat - 1'b1;
            if (len_sat == CNT_W'(1)) begin
              done_next = 1'b1;
            end else begin
              state_next = SHREG_BURST;
            end
          end
        end else begin
          shift_en = is_shift;
        end
      end
      SHREG_BURST: begin
        shift_en   = 1'b1;
        count_next = count - 1'b1;
        if (count == CNT_W'(1)) begin
          state_next = SHREG_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = SHREG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SHREG_IDLE;
      count <= '0;
      dir_q <= 1'b0;
      done  <= 1'b0;
    end else if (en) begin
      state <= state_next;
      count <= count_next;
      dir_q <= dir_next;
      done  <= done_next;
    end
  end

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised universal shift register with hold/load/shift and autonomous
// shift bursts. Optional feature macro: SHREG_ROTATE_EN (rotate instead of serial fill).
module shift_reg_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             rotate,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_len,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  logic shift_en;
  logic shift_right;
  logic load_en;
  logic fill_l;
  logic fill_r;

  shift_reg_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .start       (start),
    .shift_len   (shift_len),
    .busy        (busy),
    .done        (done),
    .shift_en    (shift_en),
    .shift_right (shift_right)
  );

`ifdef SHREG_ROTATE_EN
  assign fill_l = rotate ? q[0]       : sin_l;
  assign fill_r = rotate ? q[WIDTH-1] : sin_r;
`else
  logic unused_rotate;
  assign unused_rotate = rotate;
  assign fill_l = sin_l;
  assign fill_r = sin_r;
`endif

  // Manual loads are blocked while a burst owns the register.
  assign load_en = !busy && (shreg_mode_e'(mode) == SHREG_LOAD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      if (shift_en) begin
        q <= shift_right ? {fill_l, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill_r};
      end else if (load_en) begin
        q <= din;
      end
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_shift_reg_n.sv
// Self-checking bench for shift_reg_n: vector table, burst corner sequences,
// and randomized traffic against a shift-count based reference model.
module tb_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, en, sin_l, sin_r, rotate, start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] din;
  logic [CNT_W-1:0] shift_len;
  logic [WIDTH-1:0] q;
  logic             sout_l, sout_r, busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: register value plus number of burst shifts still owed.
  logic [7:0] m_q;
  int         m_left;
  logic       m_right;
  logic       m_done;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic       sin_l;
    logic       sin_r;
    logic       en;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .din       (din),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .rotate    (rotate),
    .start     (start),
    .shift_len (shift_len),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] shifted(logic [7:0] v, logic right);
    logic fill;
    if (right) begin
      fill = sin_l;
`ifdef SHREG_ROTATE_EN
      if (rotate) fill = v[0];
`endif
      return (v >> 1) | (fill ? 8'h80 : 8'h00);
    end
    fill = sin_r;
`ifdef SHREG_ROTATE_EN
    if (rotate) fill = v[7];
`endif
    return (v << 1) | (fill ? 8'h01 : 8'h00);
  endfunction

  task automatic model_step();
    int   n;
    logic ndone;
    if (!rst_n) begin
      m_q    = 8'h00;
      m_left = 0;
      m_done = 1'b0;
    end else if (en) begin
      ndone = 1'b0;
      if (m_left > 0) begin
        m_q    = shifted(m_q, m_right);
        m_left = m_left - 1;
        ndone  = (m_left == 0);
      end else if (start && (mode == 2'd1 || mode == 2'd2)) begin
        n = (int'(shift_len) > WIDTH) ? WIDTH : int'(shift_len);
        if (n == 0) begin
          ndone = 1'b1;
        end else begin
          m_right = (mode == 2'd2);
          m_q     = shifted(m_q, m_right);
          m_left  = n - 1;
          ndone   = (m_left == 0);
        end
      end else begin
        case (mode)
          2'd1:    m_q = shifted(m_q, 1'b0);
          2'd2:    m_q = shifted(m_q, 1'b1);
          2'd3:    m_q = din;
          default: ;
        endcase
      end
      m_done = ndone;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
    check("sout_l", 32'(sout_l), 32'(m_q[7]));
    check("sout_r", 32'(sout_r), 32'(m_q[0]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(vec_t v);
    mode  = v.mode;
    din   = v.din;
    sin_l = v.sin_l;
    sin_r = v.sin_r;
    en    = v.en;
  endtask

  task automatic wait_done(string name, int bound, output int edges);
    edges = 0;
    while (!done && edges < bound) begin
      tick();
      edges++;
    end
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    int edges;

    rst_n = 1'b0; en = 1'b1; mode = 2'd3; din = 8'hFF;
    sin_l = 1'b0; sin_r = 1'b0; rotate = 1'b0; start = 1'b0; shift_len = '0;
    m_q = 8'h00; m_left = 0; m_right = 1'b0; m_done = 1'b0;

    // Reset holds even while LOAD is requested.
    tick();
    tick();
    check("rst_q", 32'(q), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_load", 32'(q), 32'hFF);

    vecs[0] = '{2'd3, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[1] = '{2'd1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h4B};
    vecs[2] = '{2'd2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h25};
    vecs[3] = '{2'd3, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h25};
    vecs[4] = '{2'd1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h25};
    vecs[5] = '{2'd2, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h25};
    vecs[6] = '{2'd0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h25};
    vecs[7] = '{2'd2, 8'h00, 1'b1, 1'b0, 1'b1, 8'h92};
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      tick();
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
    end

    // Burst of 3 right shifts; a start issued mid-burst must be ignored.
    en = 1'b1; mode = 2'd3; din = 8'h81;
    tick();
    mode = 2'd2; start = 1'b1; shift_len = 4'd3; sin_l = 1'b0;
    tick();
    check("burst_e1_q", 32'(q), 32'h40);
    mode = 2'd1; start = 1'b1; shift_len = 4'd5; din = 8'h00;
    tick();
    check("burst_e2_busy", 32'(busy), 32'd1);
    start = 1'b0; mode = 2'd0;
    tick();
    check("burst_done_q", 32'(q), 32'h10);
    check("burst_done", 32'(done), 32'd1);
    tick();

    // Zero-length burst: completion only.
    mode = 2'd2; start = 1'b1; shift_len = 4'd0;
    tick();
    check("len0_done", 32'(done), 32'd1);
    check("len0_q", 32'(q), 32'h10);
    start = 1'b0; mode = 2'd0;
    tick();

    // Single-shift burst never raises busy.
    mode = 2'd1; sin_r = 1'b1; start = 1'b1; shift_len = 4'd1;
    tick();
    check("len1_q", 32'(q), 32'h21);
    check("len1_busy", 32'(busy), 32'd0);
    check("len1_done", 32'(done), 32'd1);
    start = 1'b0; mode = 2'd0;
    tick();

    // Oversized length saturates to WIDTH shifts.
    mode = 2'd3; din = 8'hFF;
    tick();
    mode = 2'd1; sin_r = 1'b0; start = 1'b1; shift_len = 4'd15;
    tick();
    start = 1'b0; mode = 2'd0;
    wait_done("len15", 20, edges);
    check("len15_edges", 32'(edges + 1), 32'd8);
    check("len15_q", 32'(q), 32'h00);

    // Back-to-back burst launched while done is high.
    mode = 2'd2; sin_l = 1'b1; start = 1'b1; shift_len = 4'd2;
    tick();
    check("b2b_busy", 32'(busy), 32'd1);
    start = 1'b0; mode = 2'd0;
    tick();
    check("b2b_q", 32'(q), 32'hC0);
    check("b2b_done", 32'(done), 32'd1);
    tick();

    // Reset on the 4th edge of an 8-shift burst aborts it silently.
    mode = 2'd1; sin_r = 1'b1; start = 1'b1; shift_len = 4'd8;
    tick();
    start = 1'b0; mode = 2'd0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_q", 32'(q), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_no_done", 32'(done), 32'd0);

    // Rotating left burst of WIDTH returns the original pattern when enabled.
    mode = 2'd3; din = 8'h81;
    tick();
    mode = 2'd1; rotate = 1'b1; sin_r = 1'b0; start = 1'b1; shift_len = 4'd8;
    tick();
    start = 1'b0;
    wait_done("rotate", 20, edges);
`ifdef SHREG_ROTATE_EN
    check("rotate_q", 32'(q), 32'h81);
`else
    check("rotate_q", 32'(q), 32'h00);
`endif
    rotate = 1'b0; mode = 2'd0;
    tick();

    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      en        = ($urandom_range(0, 4) != 0);
      mode      = 2'($urandom_range(0, 3));
      din       = 8'($urandom);
      sin_l     = 1'($urandom);
      sin_r     = 1'($urandom);
      rotate    = 1'($urandom);
      start     = ($urandom_range(0, 2) == 0);
      shift_len = 4'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised universal shift register, successor to the single-bit `DFF` storage cell. It provides a WIDTH-bit register with hold, parallel load, and left or right shift from serial inputs. A burst controller performs a programmed number of shifts autonomously and signals completion. It is used as the serialiser/deserialiser and delay stage in the datapath blocks built on the `DFF` primitive.

## Interface
- `WIDTH`, 8, register width in bits (≥2)
- `CNT_W`, `$clog2(WIDTH+1)`, width of burst length/count
- `clk` in 1 — rising-edge clock
- `rst_n` in 1 — synchronous, active-low reset
- `en` in 1 — clock enable; low freezes all state (register, FSM, counter)
- `mode` in 2 — 0 HOLD, 1 SHL, 2 SHR, 3 LOAD
- `din` in WIDTH — parallel load data
- `sin_l` in 1 — serial in for SHR (enters at MSB)
- `sin_r` in 1 — serial in for SHL (enters at LSB)
- `rotate` in 1 — rotate request (effective only with `SHREG_ROTATE_EN`)
- `start` in 1 — launch burst of `shift_len` shifts in direction `mode`
- `shift_len` in CNT_W — burst length, 0..WIDTH
- `q` out WIDTH — register contents
- `sout_l` out 1 — `q[WIDTH-1]`, combinational
- `sout_r` out 1 — `q[0]`, combinational
- `busy` out 1 — burst in progress
- `done` out 1 — one-cycle pulse when a burst completes

## Operation
- FSM states: IDLE, BURST.
- IDLE, `en`=1, `start`=0: apply `mode` once per cycle. SHL: `q <= {q[WIDTH-2:0], sin_r}`. SHR: `q <= {sin_l, q[WIDTH-1:1]}`. LOAD: `q <= din`. HOLD: no change.
- IDLE, `en`=1, `start`=1, `mode` ∈ {SHL, SHR}, `shift_len`>0:
  - Latch direction and `shift_len` into the counter.
  - Perform the first shift in the same edge.
  - Go to BURST with count = `shift_len`−1.
  - If `shift_len`=1, stay IDLE and pulse `done`.
- `start` with `shift_len`=0: no shift; `done` pulses next cycle; stay IDLE.
- `start` with `mode` HOLD or LOAD: treated as a manual operation; no burst and no `done`.
- BURST, `en`=1: shift once per cycle in the latched direction.
  - `mode`, `start`, `din` and `shift_len` are ignored.
  - Serial inputs are sampled live each cycle.
  - When the count reaches 0 after a shift, return to IDLE and pulse `done`.
- `en`=0 in any state: q, FSM, counter and `done` hold. `done` is never extended: it is registered and clears on the next enabled edge.
- `shift_len` > WIDTH saturates to WIDTH.

## Timing
- Reset values (rst_n sampled low at posedge): `q`=0, `busy`=0, `done`=0, FSM=IDLE, counter=0. `sout_l` and `sout_r` are consequently 0.
- Reset asserted mid-burst aborts the burst with no `done` pulse. Reset overrides `en`.
- Manual operations have 1-cycle latency: q reflects the operation after the same posedge.
- A burst of N≥1 shifts:
  - q changes on N consecutive enabled edges.
  - `busy`=1 from edge 1 to edge N−1.
  - `done`=1 for the cycle following edge N, aligned with the final q.
- `start` while `busy`=1 is ignored.
- A new `start` in the same cycle `done` is high is accepted (back-to-back bursts).

## Configuration
- `SHREG_ROTATE_EN` defined:
  - When `rotate`=1, SHL feeds `q[WIDTH-1]` into the LSB and SHR feeds `q[0]` into the MSB, replacing `sin_r`/`sin_l`.
  - Applies to both manual and burst shifts; `rotate` is sampled every cycle.
- Not defined: the `rotate` port exists but is ignored; shifts always use serial inputs.

## Structure
- Package `shift_reg_pkg`:
  - `typedef enum logic [1:0] shreg_mode_e {SHREG_HOLD, SHREG_SHL, SHREG_SHR, SHREG_LOAD}`.
  - FSM state enum `shreg_state_e {SHREG_IDLE, SHREG_BURST}`.
- Sub-module `shift_reg_ctrl`: burst FSM plus down-counter, producing `busy`, `done`, a shift-enable and the latched direction. The datapath stays in `shift_reg_n`.

## Test plan
- Reset: `rst_n`=0 over two edges with `din`=8'hFF and `mode`=LOAD → `q`=8'h00, `busy`=0, `done`=0; then `rst_n`=1 with LOAD → `q`=8'hFF one edge later.
- Manual shifts: LOAD 8'hA5, then SHL with `sin_r`=1 → 8'h4B; then SHR with `sin_l`=0 → 8'h25; with `en`=0 for 3 cycles, q stays 8'h25.
- Burst: LOAD 8'h81, then `start` SHR, `shift_len`=3, `sin_l`=0 → `busy` high 2 cycles, then `done` pulses with `q`=8'h10; a `start` issued mid-burst is ignored.
- Edge lengths: `shift_len`=0 → `done` next cycle, q unchanged; `shift_len`=1 → one shift, `done` next cycle, `busy` never high; `shift_len`=15 → exactly 8 shifts.
- Reset mid-burst: `shift_len`=8, `rst_n`=0 on 4th cycle → `q`=0, `busy`=0, no `done`.
- Rotate (compiled with `SHREG_ROTATE_EN`): LOAD 8'h81, `rotate`=1, SHL burst of 8 → q returns to 8'h81 and `done` pulses; compiled without the macro, the same stimulus with `sin_r`=0 → 8'h00.
